// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner with hex decode, leading-zero blanking and a blinking overflow dash.
// Inputs are latched once per frame so a single scan never mixes old and new values.
module seg_scan_driver #(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   data_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    overflow,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     dig,
    output logic                    frame_done
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int BW = $clog2(2 * BLINK_FRAMES);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);
    localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    // run is clear only in the cycle right after reset, so the first released edge captures a frame.
    logic                  run;
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic [BW-1:0]         blink, blink_n;
    logic [4*N_DIGITS-1:0] sh_data, sh_data_n;
    logic [N_DIGITS-1:0]   sh_dp, sh_dp_n;
    logic                  sh_ov, sh_ov_n, sh_lz, sh_lz_n;
    logic                  cap, zeros, blank, dp_bit;
    logic [3:0]            nib;
    logic [6:0]            seg_hi;
    logic                  dp_hi;
    logic [N_DIGITS-1:0]   dig_hi;
    logic                  fd_n;

    always_comb begin
        cap   = 1'b0;
        cnt_n = cnt + 1'b1;
        idx_n = idx;
        if (!run) begin
            cnt_n = '0;
            idx_n = '0;
            cap   = 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (idx == IDX_LAST) begin
                idx_n = '0;
                cap   = 1'b1;
            end else begin
                idx_n = idx + 1'b1;
            end
        end

        sh_data_n = cap ? data_in  : sh_data;
        sh_dp_n   = cap ? dp_in    : sh_dp;
        sh_ov_n   = cap ? overflow : sh_ov;
        sh_lz_n   = cap ? lz_en    : sh_lz;

        // The counter advances only across consecutive overflow frames; any other capture restarts it visible.
        blink_n = blink;
        if (cap) begin
            if (overflow && sh_ov)
                blink_n = (blink == BLINK_LAST) ? '0 : blink + 1'b1;
            else
                blink_n = '0;
        end

        nib    = sh_data_n[3:0];
        dp_bit = sh_dp_n[0];
        blank  = 1'b0;
        zeros  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zeros = zeros && (sh_data_n[4*i +: 4] == 4'h0);
            if (idx_n == IW'(i)) begin
                nib    = sh_data_n[4*i +: 4];
                dp_bit = sh_dp_n[i];
                blank  = sh_lz_n && zeros;
            end
        end

        if (sh_ov_n) begin
            seg_hi = (blink_n >= BLINK_HALF) ? 7'b0000000 : 7'b0000001;
            dp_hi  = 1'b0;
        end else begin
            seg_hi = blank ? 7'b0000000 : hex7(nib);
            dp_hi  = dp_bit;
        end
        if (cnt_n == '0) begin
            seg_hi = 7'b0000000;
            dp_hi  = 1'b0;
        end

        for (int i = 0; i < N_DIGITS; i++)
            dig_hi[i] = (cnt_n != '0) && (idx_n == IW'(i));

        fd_n = (cnt_n == CNT_LAST) && (idx_n == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run        <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            blink      <= '0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_ov      <= 1'b0;
            sh_lz      <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            dig        <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            run        <= 1'b1;
            cnt        <= cnt_n;
            idx        <= idx_n;
            blink      <= blink_n;
            sh_data    <= sh_data_n;
            sh_dp      <= sh_dp_n;
            sh_ov      <= sh_ov_n;
            sh_lz      <= sh_lz_n;
            seg        <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
            dp         <= SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
            dig        <= DIG_ACTIVE_LOW ? ~dig_hi : dig_hi;
            frame_done <= fd_n;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: per-cycle expectations from a frame-level display model go into a queue,
// and a monitor compares the pins one cycle later.
module tb_seg_scan_driver;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = ND * SD;
    localparam logic [6:0] HEX_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        overflow = 1'b0;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig;
    logic        frame_done;

    seg_scan_driver #(.N_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
                      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .overflow(overflow),
        .lz_en(lz_en), .seg(seg), .dp(dp), .dig(dig), .frame_done(frame_done));

    // clock / reset
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // scoreboard: {check_seg, frame_done, dp, seg[6:0], dig[3:0]}
    logic [13:0] exp_q[$];
    int vectors = 0;
    int errors = 0;
    bit running = 1'b0;

    // reference model state: cycles since release and the values latched for the current frame
    int          t = 0;
    int          ovrun = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;
    logic        m_ov = 1'b0;
    logic        m_lz = 1'b0;

    task automatic step(input logic [15:0] d, input logic [3:0] p, input logic o, input logic l, input logic r);
        logic [13:0] e;
        logic [15:0] upper;
        logic [3:0]  one;
        logic [6:0]  hi;
        logic        dpv, fd;
        int pos, di, c;
        @(negedge clk);
        data_in = d; dp_in = p; overflow = o; lz_en = l; rst_n = r;
        if (!r) begin
            e = {1'b1, 1'b0, 1'b1, 7'h7F, 4'hF};
            t = 0;
            ovrun = 0;
        end else begin
            pos = t % FRAME;
            if (pos == 0) begin
                m_data = d; m_dp = p; m_ov = o; m_lz = l;
                ovrun = o ? ovrun + 1 : 0;
            end
            di = pos / SD;
            c  = pos % SD;
            fd = (pos == FRAME - 1);
            if (c == 0) begin
                e = {1'b0, fd, 1'b1, 7'h7F, 4'hF};
            end else begin
                one   = 4'b0001 << di;
                upper = m_data >> (4 * di);
                if (m_ov) begin
                    hi  = (((ovrun - 1) / BF) % 2 == 0) ? 7'b0000001 : 7'b0000000;
                    dpv = 1'b0;
                end else begin
                    hi  = (m_lz && di > 0 && upper == 16'h0) ? 7'b0000000 : HEX_TAB[upper[3:0]];
                    dpv = m_dp[di];
                end
                e = {1'b1, fd, ~dpv, ~hi, ~one};
            end
            t++;
        end
        exp_q.push_back(e);
        running = 1'b1;
    endtask

    task automatic run_cycles(input int n, input logic [15:0] d, input logic [3:0] p, input logic o, input logic l);
        for (int i = 0; i < n; i++) step(d, p, o, l, 1'b1);
    endtask

    // monitor
    initial begin
        logic [13:0] e;
        logic [12:0] act, mask;
        wait (running);
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL queue_underrun: output at %0t has no expectation", $time);
            end else begin
                e    = exp_q.pop_front();
                act  = {frame_done, dp, seg, dig};
                mask = e[13] ? 13'h1FFF : 13'h100F;
                vectors++;
                if ((act & mask) != (e[12:0] & mask)) begin
                    errors++;
                    $display("FAIL pins @%0t: got fd=%b dp=%b seg=%b dig=%b, required fd=%b dp=%b seg=%b dig=%b (seg checked=%b)",
                             $time, frame_done, dp, seg, dig, e[12], e[11], e[10:4], e[3:0], e[13]);
                end
            end
        end
    end

    // stimulus
    initial begin
        logic [15:0] bd, d;
        logic [3:0]  bp;
        logic        bo, bl;
        for (int i = 0; i < 3; i++)
            step(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        run_cycles(2 * FRAME, 16'h12AF, 4'h0, 1'b0, 1'b0);
        // frame sync: new value arrives in the idx=2 slot
        run_cycles(FRAME, 16'h1111, 4'h0, 1'b0, 1'b0);
        run_cycles(FRAME / 2, 16'h1111, 4'h0, 1'b0, 1'b0);
        run_cycles(FRAME / 2, 16'h2222, 4'h0, 1'b0, 1'b0);
        run_cycles(FRAME, 16'h2222, 4'h0, 1'b0, 1'b0);
        run_cycles(2 * FRAME, 16'h0040, 4'b1000, 1'b0, 1'b1);
        run_cycles(2 * FRAME, 16'h0000, 4'b0000, 1'b0, 1'b1);
        for (int f = 0; f < 10; f++)
            run_cycles(FRAME, 16'($urandom), 4'($urandom), 1'b1, 1'($urandom));
        run_cycles(2 * FRAME, 16'h5A3C, 4'b0101, 1'b0, 1'b0);
        // reset in the middle of the idx=2 slot
        run_cycles(FRAME / 2 + 1, 16'h9876, 4'h0, 1'b0, 1'b0);
        step(16'h9876, 4'h0, 1'b0, 1'b0, 1'b0);
        step(16'h9876, 4'h0, 1'b0, 1'b0, 1'b0);
        run_cycles(FRAME, 16'h0BCD, 4'b0010, 1'b0, 1'b1);
        // random frames: inputs held at the capture cycle, scrambled elsewhere
        bd = '0; bp = '0; bo = 1'b0; bl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (t % FRAME == 0) begin
                d  = 16'($urandom);
                bd = d & (16'hFFFF >> (4 * $urandom_range(0, 4)));
                bp = 4'($urandom);
                bo = ($urandom_range(0, 2) == 0);
                bl = 1'($urandom);
                step(bd, bp, bo, bl, ($urandom_range(0, 99) != 0));
            end else if ($urandom_range(0, 199) == 0) begin
                step(bd, bp, bo, bl, 1'b0);
            end else begin
                step(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            end
        end
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
